// File: rtl/weight_load_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_load_sequencer_pkg
// Description : Shared state encoding and defaults for the weight load sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package weight_load_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_W_SRC   = 4'd1,
        S_W_START = 4'd2,
        S_W_WAIT  = 4'd3,
        S_W_ACK   = 4'd4,
        S_R_START = 4'd5,
        S_R_WAIT  = 4'd6,
        S_R_ACK   = 4'd7,
        S_C_START = 4'd8,
        S_C_WAIT  = 4'd9,
        S_NEXT    = 4'd10,
        S_ERROR   = 4'd11
    } wls_state_e;

    localparam int c_DEFAULT_TIMEOUT_CYCLES = 1023;

endpackage
`default_nettype wire

// File: rtl/weight_load_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wls_watchdog
// Description : Wait-state cycle counter; flags expiry on the last allowed cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wls_watchdog #(
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TIMEOUT_WIDTH-1:0] c_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TIMEOUT_WIDTH'(1);
        end
    end

    // Count equals cycles already spent in the state, so this is the Nth cycle.
    assign o_expired = i_enable && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/weight_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : weight_load_sequencer
// Description : Sequences OWMC weight/register loads and PE passes per filter/channel.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_load_sequencer
    import weight_load_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 WLS_Clk,
    input  logic                 WLS_Reset,
    input  logic                 WLS_Start,
    input  logic                 WLS_Abort,
    input  logic [CNT_WIDTH-1:0] WLS_Num_Filters,
    input  logic [CNT_WIDTH-1:0] WLS_Num_Channels,
    input  logic                 WLS_Weights_Avail,
    input  logic                 WLS_Owmc_Loading_Weights_Already,
    input  logic                 WLS_Owmc_Loading_Regs_Already,
    input  logic                 WLS_Conv_Done,
    output logic                 WLS_Owmc_Reset,
    output logic                 WLS_Owmc_Start_Loading_Weights,
    output logic                 WLS_Owmc_Start_Loading_Regs,
    output logic                 WLS_Owmc_Loading_Weights_Already_Ok,
    output logic                 WLS_Owmc_Loading_Regs_Already_Ok,
    output logic                 WLS_Conv_Start,
    output logic                 WLS_Busy,
    output logic                 WLS_Done,
    output logic                 WLS_Error,
    output logic [CNT_WIDTH-1:0] WLS_Filter_Idx,
    output logic [CNT_WIDTH-1:0] WLS_Channel_Idx
);

    wls_state_e           r_state, w_next_state;
    logic [CNT_WIDTH-1:0] r_num_filters, w_next_num_filters;
    logic [CNT_WIDTH-1:0] r_num_channels, w_next_num_channels;
    logic [CNT_WIDTH-1:0] r_filter_idx, w_next_filter_idx;
    logic [CNT_WIDTH-1:0] r_channel_idx, w_next_channel_idx;
    logic                 r_error, w_next_error;
    logic                 w_owmc_reset, w_done;
    logic                 r_owmc_reset, r_start_w, r_start_r, r_ok_w, r_ok_r;
    logic                 r_conv_start, r_busy, r_done;
    logic                 w_wd_enable, w_wd_clear, w_wd_expired;

    assign w_wd_enable = (r_state == S_W_WAIT) || (r_state == S_R_WAIT) || (r_state == S_C_WAIT);
    assign w_wd_clear  = (w_next_state != r_state);

    wls_watchdog #(
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (WLS_Clk),
        .rst       (WLS_Reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    always_comb begin
        w_next_state        = r_state;
        w_next_num_filters  = r_num_filters;
        w_next_num_channels = r_num_channels;
        w_next_filter_idx   = r_filter_idx;
        w_next_channel_idx  = r_channel_idx;
        w_next_error        = r_error;
        w_owmc_reset        = 1'b0;
        w_done              = 1'b0;
        if (WLS_Abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
            w_owmc_reset = 1'b1;
        end else if (w_wd_expired) begin
            w_next_state = S_ERROR;
            w_next_error = 1'b1;
            w_owmc_reset = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (WLS_Start) begin
                        w_next_num_filters  = WLS_Num_Filters;
                        w_next_num_channels = WLS_Num_Channels;
                        w_next_filter_idx   = '0;
                        w_next_channel_idx  = '0;
                        w_next_error        = 1'b0;
                        w_next_state        = S_W_SRC;
                    end
                end
                S_W_SRC:   if (WLS_Weights_Avail) w_next_state = S_W_START;
                S_W_START: w_next_state = S_W_WAIT;
                S_W_WAIT:  if (WLS_Owmc_Loading_Weights_Already) w_next_state = S_W_ACK;
                S_W_ACK:   w_next_state = S_R_START;
                S_R_START: w_next_state = S_R_WAIT;
                S_R_WAIT:  if (WLS_Owmc_Loading_Regs_Already) w_next_state = S_R_ACK;
                S_R_ACK:   w_next_state = S_C_START;
                S_C_START: w_next_state = S_C_WAIT;
                S_C_WAIT:  if (WLS_Conv_Done) w_next_state = S_NEXT;
                S_NEXT: begin
                    if (r_channel_idx != r_num_channels) begin
                        w_next_channel_idx = r_channel_idx + CNT_WIDTH'(1);
                        w_next_state       = S_R_START;
                    end else if (r_filter_idx != r_num_filters) begin
                        w_next_filter_idx  = r_filter_idx + CNT_WIDTH'(1);
                        w_next_channel_idx = '0;
                        w_next_state       = S_W_SRC;
                    end else begin
                        w_done       = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    // Pulse outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge WLS_Clk) begin
        if (WLS_Reset) begin
            r_state        <= S_IDLE;
            r_num_filters  <= '0;
            r_num_channels <= '0;
            r_filter_idx   <= '0;
            r_channel_idx  <= '0;
            r_error        <= 1'b0;
            r_owmc_reset   <= 1'b0;
            r_start_w      <= 1'b0;
            r_start_r      <= 1'b0;
            r_ok_w         <= 1'b0;
            r_ok_r         <= 1'b0;
            r_conv_start   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_num_filters  <= w_next_num_filters;
            r_num_channels <= w_next_num_channels;
            r_filter_idx   <= w_next_filter_idx;
            r_channel_idx  <= w_next_channel_idx;
            r_error        <= w_next_error;
            r_owmc_reset   <= w_owmc_reset;
            r_start_w      <= (w_next_state == S_W_START);
            r_start_r      <= (w_next_state == S_R_START);
            r_ok_w         <= (w_next_state == S_W_ACK);
            r_ok_r         <= (w_next_state == S_R_ACK);
            r_conv_start   <= (w_next_state == S_C_START);
            r_busy         <= (w_next_state != S_IDLE) && (w_next_state != S_ERROR);
            r_done         <= w_done;
        end
    end

    assign WLS_Owmc_Reset                      = r_owmc_reset;
    assign WLS_Owmc_Start_Loading_Weights      = r_start_w;
    assign WLS_Owmc_Start_Loading_Regs         = r_start_r;
    assign WLS_Owmc_Loading_Weights_Already_Ok = r_ok_w;
    assign WLS_Owmc_Loading_Regs_Already_Ok    = r_ok_r;
    assign WLS_Conv_Start                      = r_conv_start;
    assign WLS_Busy                            = r_busy;
    assign WLS_Done                            = r_done;
    assign WLS_Error                           = r_error;
    assign WLS_Filter_Idx                      = r_filter_idx;
    assign WLS_Channel_Idx                     = r_channel_idx;

endmodule
`default_nettype wire

// File: tb/tb_weight_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_load_sequencer
// Description : Randomized bench with OWMC/PE responders and an event-sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_weight_load_sequencer;

    localparam int CW = 8;
    localparam int TO = 16;
    localparam int K_W = 1, K_R = 2, K_C = 3, K_D = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort, avail, wa, ra, cdone;
    logic [CW-1:0] num_f, num_c;
    logic          o_oreset, o_sw, o_sr, o_wok, o_rok, o_cs, o_busy, o_done, o_error;
    logic [CW-1:0] o_fidx, o_cidx;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    weight_load_sequencer #(
        .CNT_WIDTH      (CW),
        .TIMEOUT_WIDTH  (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .WLS_Clk                             (clk),
        .WLS_Reset                           (rst),
        .WLS_Start                           (start),
        .WLS_Abort                           (abort),
        .WLS_Num_Filters                     (num_f),
        .WLS_Num_Channels                    (num_c),
        .WLS_Weights_Avail                   (avail),
        .WLS_Owmc_Loading_Weights_Already    (wa),
        .WLS_Owmc_Loading_Regs_Already       (ra),
        .WLS_Conv_Done                       (cdone),
        .WLS_Owmc_Reset                      (o_oreset),
        .WLS_Owmc_Start_Loading_Weights      (o_sw),
        .WLS_Owmc_Start_Loading_Regs         (o_sr),
        .WLS_Owmc_Loading_Weights_Already_Ok (o_wok),
        .WLS_Owmc_Loading_Regs_Already_Ok    (o_rok),
        .WLS_Conv_Start                      (o_cs),
        .WLS_Busy                            (o_busy),
        .WLS_Done                            (o_done),
        .WLS_Error                           (o_error),
        .WLS_Filter_Idx                      (o_fidx),
        .WLS_Channel_Idx                     (o_cidx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%h expected=0x%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Expected pulse sequence: {kind, filter, channel} in issue order.
    logic [31:0] exp_q[$];

    int w_lo = 3, w_hi = 3, r_lo = 3, r_hi = 3, c_lo = 5, c_hi = 5;
    bit w_never = 0, rand_avail = 0;
    int stall = 0;

    int t_ws, t_wok, t_rs, t_rok, t_cd, lw, lr, lc, w_tmr, r_tmr, c_tmr;
    int wl_cnt = 0, rl_cnt = 0, cs_cnt = 0, wok_cnt = 0, rok_cnt = 0, done_cnt = 0;
    bit from_wok;

    function automatic int ack_lat(int l);
        return ((l < 1) ? 1 : l) + 1;
    endfunction

    task automatic ev(input int k);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("event_seq", {8'd0, 8'(k), o_fidx, o_cidx}, e);
    endtask

    // Monitor plus OWMC/PE responder, all on the falling edge.
    initial begin : mon
        logic [6:0] cur, prev;
        prev = '0;
        wa = 0; ra = 0; cdone = 0; avail = 0;
        w_tmr = 0; r_tmr = 0; c_tmr = 0; from_wok = 0;
        t_ws = 0; t_wok = 0; t_rs = 0; t_rok = 0; t_cd = 0; lw = 0; lr = 0; lc = 0;
        forever begin
            @(negedge clk);
            if (rst) continue;
            cur = {o_sw, o_sr, o_wok, o_rok, o_cs, o_done, o_oreset};
            if (cur != 0) check("pulse_width", 32'(cur & prev), 32'd0);
            prev = cur;
            if (o_sw)  begin ev(K_W); wl_cnt++; t_ws = cyc; end
            if (o_wok) begin wok_cnt++; check("w_ack_lat", cyc - t_ws, ack_lat(lw)); t_wok = cyc; from_wok = 1; end
            if (o_sr)  begin
                ev(K_R); rl_cnt++;
                check("r_start_lat", cyc, from_wok ? t_wok + 1 : t_cd + 2);
                from_wok = 0; t_rs = cyc;
            end
            if (o_rok) begin rok_cnt++; check("r_ack_lat", cyc - t_rs, ack_lat(lr)); t_rok = cyc; end
            if (o_cs)  begin ev(K_C); cs_cnt++; check("c_start_lat", cyc, t_rok + 1); end
            if (o_done) begin
                ev(K_D); done_cnt++;
                check("done_lat", cyc, t_cd + 2);
                check("busy_on_done", o_busy, 0);
            end
            cdone = 0;
            if (o_oreset) begin wa = 0; ra = 0; w_tmr = 0; r_tmr = 0; from_wok = 0; end
            if (o_wok) wa = 0;
            if (o_rok) ra = 0;
            if (w_tmr > 0) begin w_tmr--; if (w_tmr == 0) wa = 1; end
            if (r_tmr > 0) begin r_tmr--; if (r_tmr == 0) ra = 1; end
            if (c_tmr > 0) begin c_tmr--; if (c_tmr == 0) begin cdone = 1; t_cd = cyc; end end
            if (o_sw && !w_never) begin
                lw = $urandom_range(w_hi, w_lo);
                if (lw == 0) wa = 1; else w_tmr = lw;
            end
            if (o_sr) begin
                lr = $urandom_range(r_hi, r_lo);
                if (lr == 0) ra = 1; else r_tmr = lr;
            end
            if (o_cs) begin lc = $urandom_range(c_hi, c_lo); c_tmr = lc; end
            if (stall > 0) begin avail = 0; stall--; end
            else avail = rand_avail ? ($urandom_range(3, 0) != 0) : 1'b1;
        end
    end

    task automatic build_q(input int f_n, input int c_n);
        for (int f = 0; f <= f_n; f++) begin
            exp_q.push_back({8'd0, 8'(K_W), 8'(f), 8'd0});
            for (int c = 0; c <= c_n; c++) begin
                exp_q.push_back({8'd0, 8'(K_R), 8'(f), 8'(c)});
                exp_q.push_back({8'd0, 8'(K_C), 8'(f), 8'(c)});
            end
        end
        exp_q.push_back({8'd0, 8'(K_D), 8'(f_n), 8'(c_n)});
    endtask

    task automatic start_job(input int f_n, input int c_n, input bit with_abort);
        build_q(f_n, c_n);
        num_f = CW'(f_n); num_c = CW'(c_n);
        start = 1; abort = with_abort;
        @(negedge clk);
        start = 0; abort = 0;
        num_f = CW'($urandom); num_c = CW'($urandom);
        check("busy_after_start", o_busy, 1);
        check("error_after_start", o_error, 0);
    endtask

    task automatic run_job(input int f_n, input int c_n, input bit with_abort);
        int wl0, rl0, cs0, wok0, rok0, d0, n;
        wl0 = wl_cnt; rl0 = rl_cnt; cs0 = cs_cnt; wok0 = wok_cnt; rok0 = rok_cnt; d0 = done_cnt; n = 0;
        start_job(f_n, c_n, with_abort);
        while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
        check("job_done_count", done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        check("weight_loads", wl_cnt - wl0, f_n + 1);
        check("weight_acks", wok_cnt - wok0, f_n + 1);
        check("reg_loads", rl_cnt - rl0, (f_n + 1) * (c_n + 1));
        check("reg_acks", rok_cnt - rok0, (f_n + 1) * (c_n + 1));
        check("conv_starts", cs_cnt - cs0, (f_n + 1) * (c_n + 1));
        check("final_idx", {o_fidx, o_cidx}, {8'(f_n), 8'(c_n)});
        check("error_clear", o_error, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin : main
        int n, d0, t_err;
        rst = 1; start = 0; abort = 0; num_f = 0; num_c = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {o_oreset, o_sw, o_sr, o_wok, o_rok, o_cs, o_busy, o_done, o_error, o_fidx, o_cidx}, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        // Two filters by three channels with fixed latencies.
        run_job(1, 2, 0);

        // Host stalls well past the watchdog limit; no error expected.
        stall = 50;
        run_job(0, 0, 0);

        // Register-load complete already high when R_WAIT is entered.
        r_lo = 0; r_hi = 0;
        run_job(0, 1, 0);
        r_lo = 3; r_hi = 3;

        // Weight load never completes: watchdog fires.
        w_never = 1;
        start_job(0, 0, 0);
        n = 0;
        while (!o_error && n < 200) begin @(negedge clk); n++; end
        t_err = cyc;
        check("err_seen", o_error, 1);
        check("err_time", t_err, t_ws + 1 + TO);
        check("err_oreset", o_oreset, 1);
        check("err_busy", o_busy, 0);
        exp_q.delete();
        @(negedge clk);
        check("err_sticky", {o_error, o_oreset}, 2'b10);
        w_never = 0;
        run_job(0, 0, 0);

        // Abort in C_WAIT of the second filter.
        start_job(1, 1, 0);
        n = 0;
        while (!(o_cs && o_fidx == 1) && n < 500) begin @(negedge clk); n++; end
        check("abort_reach_cstart", {o_cs, o_fidx}, {1'b1, 8'd1});
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_oreset", o_oreset, 1);
        check("abort_busy", o_busy, 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", {o_busy, o_error}, 0);

        // Start pulses while busy carry different counts and must be ignored.
        fork
            run_job(1, 1, 0);
            begin
                for (int i = 0; i < 3; i++) begin
                    repeat (10) @(negedge clk);
                    num_f = 3; num_c = 3; start = 1;
                    @(negedge clk);
                    start = 0;
                end
            end
        join

        // Start together with Abort in IDLE launches the run.
        run_job(0, 1, 1);

        // Waits one cycle short of the watchdog limit.
        w_lo = 15; w_hi = 15; r_lo = 15; r_hi = 15; c_lo = 15; c_hi = 15;
        run_job(0, 0, 0);

        // Randomized jobs.
        w_lo = 0; w_hi = 5; r_lo = 0; r_hi = 5; c_lo = 1; c_hi = 6;
        rand_avail = 1;
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(2, 0), $urandom_range(3, 0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
